rom_read_arbiter: RTL and testbench

Round-robin burst-read arbiter that shares the single synchronous-read port of a CNN weight/image BRAM ROM between `NUM_REQ` requesters, such as a convolution engine and a dense-layer engine. Each requester hands over a start address and a burst length with a valid/ready handshake. The arbiter walks the ROM addresses and tags every returned word with the requester ID and a last-beat flag. It sits between the layer engines and one ROM instance with 1-cycle read latency.

---
 rtl/rom_read_arbiter.sv | 147 ++++++++++++++
 tb/tb_rom_read_arbiter.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rom_read_arbiter.sv
// Round-robin burst-read arbiter sharing one 1-cycle-latency ROM read port
// between NUM_REQ requesters; every returned word is tagged with owner ID and last flag.
module rom_read_arbiter #(
    parameter int NUM_REQ    = 2,
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 4,
    localparam int ID_W      = $clog2(NUM_REQ)
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_len,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic [ADDR_WIDTH-1:0]         rom_addr,
    input  logic [DATA_WIDTH-1:0]         rom_data,
    output logic                          rsp_valid,
    output logic [DATA_WIDTH-1:0]         rsp_data,
    output logic [ID_W-1:0]               rsp_id,
    output logic                          rsp_last,
    output logic                          busy
);

    localparam int IDX_W = ID_W + 1;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_BURST = 1'b1
    } state_t;

    state_t                  state_r, state_nxt_s;
    logic [ADDR_WIDTH-1:0]   rom_addr_r, rom_addr_nxt_s;
    logic [ADDR_WIDTH-1:0]   beat_cnt_r, beat_cnt_nxt_s;
    logic [ID_W-1:0]         rr_ptr_r, rr_ptr_nxt_s;
    logic [ID_W-1:0]         id_r, id_nxt_s;
    logic [ID_W-1:0]         grant_id_s;
    logic [ID_W-1:0]         cand_s;
    logic                    found_s;
    logic [NUM_REQ-1:0]      grant_s;
    logic [ADDR_WIDTH-1:0]   sel_addr_s, sel_len_s;
    logic                    issue_s, last_s;
    logic                    rsp_valid_r, rsp_last_r;
    logic [ID_W-1:0]         rsp_id_r;

    // Requester index base+offs folded back into 0..NUM_REQ-1 (sum never reaches 2*NUM_REQ).
    function automatic logic [ID_W-1:0] rr_index(input logic [ID_W-1:0] base, input int unsigned offs);
        logic [IDX_W-1:0] sum;
        sum = {1'b0, base} + IDX_W'(offs);
        return (sum >= IDX_W'(NUM_REQ)) ? ID_W'(sum - IDX_W'(NUM_REQ)) : ID_W'(sum);
    endfunction

    // Round-robin search starting at rr_ptr; grants only while idle.
    always_comb begin
        grant_s    = '0;
        grant_id_s = '0;
        found_s    = 1'b0;
        cand_s     = '0;
        if (state_r == ST_IDLE) begin
            for (int k = 0; k < NUM_REQ; k++) begin
                cand_s     = rr_index(rr_ptr_r, k);
                grant_id_s = (!found_s && req_valid[cand_s]) ? cand_s : grant_id_s;
                found_s    = found_s | req_valid[cand_s];
            end
            grant_s[grant_id_s] = found_s;
        end else begin
            grant_s = '0;
        end
    end

    // Mux out the granted requester's address and length slices.
    always_comb begin
        sel_addr_s = '0;
        sel_len_s  = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            sel_addr_s = (grant_id_s == ID_W'(k)) ? req_addr[k*ADDR_WIDTH +: ADDR_WIDTH] : sel_addr_s;
            sel_len_s  = (grant_id_s == ID_W'(k)) ? req_len[k*ADDR_WIDTH +: ADDR_WIDTH]  : sel_len_s;
        end
    end

    // Next-state logic: accept in IDLE, walk addresses in BURST.
    always_comb begin
        state_nxt_s    = state_r;
        rom_addr_nxt_s = rom_addr_r;
        beat_cnt_nxt_s = beat_cnt_r;
        rr_ptr_nxt_s   = rr_ptr_r;
        id_nxt_s       = id_r;
        case (state_r)
            ST_IDLE: begin
                if (found_s) begin
                    state_nxt_s    = ST_BURST;
                    rom_addr_nxt_s = sel_addr_s;
                    beat_cnt_nxt_s = sel_len_s;
                    id_nxt_s       = grant_id_s;
                    rr_ptr_nxt_s   = rr_index(grant_id_s, 1);
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_BURST: begin
                if (beat_cnt_r == '0) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    rom_addr_nxt_s = rom_addr_r + ADDR_WIDTH'(1);
                    beat_cnt_nxt_s = beat_cnt_r - ADDR_WIDTH'(1);
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    assign issue_s = (state_r == ST_BURST);
    assign last_s  = issue_s && (beat_cnt_r == '0);

    // Control state and response pipeline registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            rom_addr_r  <= '0;
            beat_cnt_r  <= '0;
            rr_ptr_r    <= '0;
            id_r        <= '0;
            rsp_valid_r <= 1'b0;
            rsp_last_r  <= 1'b0;
            rsp_id_r    <= '0;
        end else begin
            state_r     <= state_nxt_s;
            rom_addr_r  <= rom_addr_nxt_s;
            beat_cnt_r  <= beat_cnt_nxt_s;
            rr_ptr_r    <= rr_ptr_nxt_s;
            id_r        <= id_nxt_s;
            rsp_valid_r <= issue_s;
            rsp_last_r  <= last_s;
            rsp_id_r    <= id_r;
        end
    end

    assign req_ready = grant_s;
    assign rom_addr  = rom_addr_r;
    assign rsp_valid = rsp_valid_r;
    assign rsp_last  = rsp_last_r;
    assign rsp_id    = rsp_id_r;
    assign rsp_data  = rom_data;
    assign busy      = issue_s;

endmodule

// File: tb/tb_rom_read_arbiter.sv
// Self-checking bench for rom_read_arbiter: burst table, hand-written corner sequences,
// and random traffic checked cycle by cycle against a burst-schedule reference model.
module tb_rom_read_arbiter;

    localparam int NR   = 2;
    localparam int AW   = 10;
    localparam int DW   = 4;
    localparam int IW   = 1;
    localparam int MAXC = 8192;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [NR-1:0]    req_valid;
    logic [NR*AW-1:0] req_addr, req_len;
    logic [NR-1:0]    req_ready;
    logic [AW-1:0]    rom_addr;
    logic [DW-1:0]    rom_data;
    logic             rsp_valid;
    logic [DW-1:0]    rsp_data;
    logic [IW-1:0]    rsp_id;
    logic             rsp_last;
    logic             busy;

    rom_read_arbiter #(.NUM_REQ(NR), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_addr(req_addr),
        .req_len(req_len), .req_ready(req_ready), .rom_addr(rom_addr), .rom_data(rom_data),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_id(rsp_id), .rsp_last(rsp_last),
        .busy(busy)
    );

    always #5 clk = ~clk;

    // ROM: word[a] = a mod 16, one cycle read latency
    always @(posedge clk) rom_data <= rom_addr[3:0];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // requester-side state
    bit            rq_v[NR];
    int            rq_a[NR];
    int            rq_l[NR];
    bit            hold[NR];
    logic [NR-1:0] acc = '0;

    // reference model: per-cycle expected outputs derived from accepted bursts
    bit exp_v[MAXC];
    bit exp_l[MAXC];
    bit exp_b[MAXC];
    int exp_d[MAXC];
    int exp_id[MAXC];
    int exp_ra[MAXC];
    int m_ptr  = 0;
    int m_idle = 0;

    always @(negedge clk) begin
        int c, eg, a, l, j, er;
        c   = cyc;
        acc = req_valid & req_ready;
        if (!rst_n) begin
            chk("rst_rsp_valid", rsp_valid, 0);
            chk("rst_rsp_last", rsp_last, 0);
            chk("rst_rsp_id", rsp_id, 0);
            chk("rst_busy", busy, 0);
            chk("rst_req_ready", req_ready, 0);
            chk("rst_rom_addr", rom_addr, 0);
            m_ptr  = 0;
            m_idle = 0;
            for (int k = c; k < c + 40 && k < MAXC; k++) begin
                exp_v[k] = 0; exp_l[k] = 0; exp_b[k] = 0;
            end
        end else if (c + 50 < MAXC) begin
            eg = -1;
            if (c >= m_idle) begin
                for (int k = 0; k < NR; k++) begin
                    j = (m_ptr + k) % NR;
                    if (eg < 0 && req_valid[j]) eg = j;
                end
            end
            er = (eg >= 0) ? (1 << eg) : 0;
            chk("req_ready", req_ready, er);
            if (eg >= 0) begin
                a = int'(req_addr[eg*AW +: AW]);
                l = int'(req_len[eg*AW +: AW]);
                for (int b = 0; b <= l; b++) begin
                    exp_b[c+1+b]  = 1;
                    exp_ra[c+1+b] = (a + b) % 1024;
                    exp_v[c+2+b]  = 1;
                    exp_d[c+2+b]  = ((a + b) % 1024) % 16;
                    exp_id[c+2+b] = eg;
                    exp_l[c+2+b]  = (b == l);
                end
                m_idle = c + 2 + l;
                m_ptr  = (eg + 1) % NR;
            end
            chk("busy", busy, exp_b[c]);
            if (exp_b[c]) chk("rom_addr", rom_addr, exp_ra[c]);
            chk("rsp_valid", rsp_valid, exp_v[c]);
            chk("rsp_last", rsp_last, exp_l[c]);
            if (exp_v[c]) begin
                chk("rsp_data", rsp_data, exp_d[c]);
                chk("rsp_id", rsp_id, exp_id[c]);
            end
        end
    end

    task automatic drive();
        for (int i = 0; i < NR; i++) begin
            req_valid[i]         = rq_v[i];
            req_addr[i*AW +: AW] = AW'(rq_a[i]);
            req_len[i*AW +: AW]  = AW'(rq_l[i]);
        end
    endtask

    task automatic post(input int i, input int a, input int l);
        rq_v[i] = 1; rq_a[i] = a; rq_l[i] = l;
        drive();
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        for (int i = 0; i < NR; i++) if (acc[i] && !hold[i]) rq_v[i] = 0;
        drive();
        #1;
    endtask

    task automatic wait_idle();
        bit idle_ok;
        idle_ok = 0;
        for (int k = 0; k < 200 && !idle_ok; k++) begin
            idle_ok = 1;
            for (int i = 0; i < NR; i++) if (rq_v[i]) idle_ok = 0;
            if (busy || rsp_valid) idle_ok = 0;
            if (!idle_ok) step();
        end
        if (!idle_ok) chk("idle_timeout", 1, 0);
        repeat (3) step();
    endtask

    typedef struct {
        int id; int addr; int len;
        int first; int lastd; int beats;
    } vec_t;
    vec_t tbl[6];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, n_fail=%0d", n_fail);
        $fatal(1, "watchdog");
    end

    initial begin
        int nb, first, lastd, lid, grants[4], ng;
        bit done;
        tbl[0] = '{0, 5,    3, 5,  8,  4};
        tbl[1] = '{1, 1022, 3, 14, 1,  4};
        tbl[2] = '{0, 17,   0, 1,  1,  1};
        tbl[3] = '{1, 100,  7, 4,  11, 8};
        tbl[4] = '{0, 1023, 1, 15, 0,  2};
        tbl[5] = '{1, 250,  2, 10, 12, 3};

        for (int i = 0; i < NR; i++) begin rq_v[i] = 0; rq_a[i] = 0; rq_l[i] = 0; hold[i] = 0; end
        rst_n = 1'b0;
        drive();
        repeat (3) @(posedge clk);
        #1;
        chk("reset_req_ready", req_ready, 0);
        chk("reset_rsp_valid", rsp_valid, 0);
        chk("reset_busy", busy, 0);
        chk("reset_rom_addr", rom_addr, 0);
        rst_n = 1'b1;
        repeat (2) step();

        // table of single bursts
        foreach (tbl[r]) begin
            post(tbl[r].id, tbl[r].addr, tbl[r].len);
            nb = 0; first = -1; lastd = -1; lid = -1; done = 0;
            for (int k = 0; k < 40 && !done; k++) begin
                step();
                if (rsp_valid) begin
                    nb++;
                    if (nb == 1) first = rsp_data;
                    if (rsp_last) begin lastd = rsp_data; lid = rsp_id; done = 1; end
                end
            end
            chk("tbl_done", done, 1);
            chk("tbl_beats", nb, tbl[r].beats);
            chk("tbl_first", first, tbl[r].first);
            chk("tbl_last", lastd, tbl[r].lastd);
            chk("tbl_id", lid, tbl[r].id);
            wait_idle();
        end

        // single beat, then back-to-back accept of a request raised during it
        post(0, 40, 0); #1;
        chk("b2b_rdy0", req_ready, 1);
        step();
        post(1, 60, 2); #1;
        chk("b2b_rdy_busy", req_ready, 0);
        step();
        chk("b2b_single_valid", rsp_valid, 1);
        chk("b2b_single_last", rsp_last, 1);
        chk("b2b_single_data", rsp_data, 8);
        chk("b2b_rdy1", req_ready, 2);
        step();
        chk("b2b_gap", rsp_valid, 0);
        step();
        chk("b2b_next_valid", rsp_valid, 1);
        chk("b2b_next_id", rsp_id, 1);
        chk("b2b_next_data", rsp_data, 12);
        wait_idle();

        // requests raised mid-burst are ignored until IDLE
        post(0, 200, 5);
        step();
        post(1, 300, 1); #1;
        chk("ign_rdy", req_ready, 0);
        for (int k = 0; k < 5; k++) begin
            step();
            chk("ign_rdy", req_ready, 0);
        end
        step();
        chk("ign_grant", req_ready, 2);
        wait_idle();

        // asynchronous reset mid-burst
        post(0, 500, 9);
        repeat (3) step();
        chk("mid_pre_valid", rsp_valid, 1);
        for (int i = 0; i < NR; i++) rq_v[i] = 0;
        drive();
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", rsp_valid, 0);
        chk("mid_rst_busy", busy, 0);
        repeat (3) step();
        rst_n = 1'b1;
        for (int k = 0; k < 10; k++) begin
            step();
            chk("post_rst_valid", rsp_valid, 0);
        end

        // contention: both held valid, expect 0,1,0,1 after reset
        hold[0] = 1; hold[1] = 1;
        post(0, 10, 1);
        post(1, 20, 1);
        #1;
        ng = 0;
        for (int k = 0; k < 40 && ng < 4; k++) begin
            if (req_ready != '0) begin
                grants[ng] = (req_ready == 2'b10) ? 1 : 0;
                ng++;
            end
            if (ng == 4) begin hold[0] = 0; hold[1] = 0; end
            step();
        end
        hold[0] = 0; hold[1] = 0;
        chk("rr_count", ng, 4);
        for (int k = 0; k < 4; k++) chk("rr_order", grants[k], k % 2);
        wait_idle();

        // random traffic against the model
        for (int n = 0; n < 1500; n++) begin
            step();
            for (int i = 0; i < NR; i++) begin
                if (!rq_v[i] && $urandom_range(0, 3) == 0) begin
                    rq_v[i] = 1;
                    rq_a[i] = ($urandom_range(0, 3) == 0) ? $urandom_range(1016, 1023) : $urandom_range(0, 1023);
                    rq_l[i] = $urandom_range(0, 9);
                end
            end
            drive();
        end
        wait_idle();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
